// File: rtl/touch_event_decoder.sv
// touch_event_decoder: synchronise and debounce a capacitive pad line, then classify gestures
//   as single tap, double tap or long press, each reported as a one-cycle pulse.
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   touch_signal raw asynchronous pad line, 1 = contact
//   touched      debounced, synchronised touch level
//   tap_pulse    one-cycle single-tap event
//   dtap_pulse   one-cycle double-tap event (tied 0 without TOUCH_DTAP_EN)
//   long_pulse   one-cycle long-press event
//   busy         high while the gesture FSM is not idle
// Build option: define TOUCH_DTAP_EN to enable double-tap detection.
module touch_event_decoder #(
    parameter int CNT_W        = 16,
    parameter int DEBOUNCE_CYC = 1000,
    parameter int LONG_CYC     = 50000,
    parameter int DTAP_GAP_CYC = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic touch_signal,
    output logic touched,
    output logic tap_pulse,
    output logic dtap_pulse,
    output logic long_pulse,
    output logic busy
);
`ifdef TOUCH_DTAP_EN
    typedef enum logic [2:0] {IDLE, PRESS1, WAIT_GAP, PRESS2, LONG_HELD} state_t;
`else
    typedef enum logic [1:0] {IDLE, PRESS1, LONG_HELD} state_t;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYC - 1);

    logic             s1, s2, touched_d, rise, fall, hold_last;
    logic             tap_nxt, long_nxt;
    logic [CNT_W-1:0] db_cnt, hold_cnt;
    state_t           state, state_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            touched   <= 1'b0;
            touched_d <= 1'b0;
            db_cnt    <= '0;
        end else begin
            s1        <= touch_signal;
            s2        <= s1;
            touched_d <= touched;
            if (s2 == touched)
                db_cnt <= '0;
            else if (db_cnt == DB_LAST) begin
                touched <= s2;
                db_cnt  <= '0;
            end else if (db_cnt != CNT_MAX)
                db_cnt <= db_cnt + 1'b1;
        end
    end

    assign rise      = touched & ~touched_d;
    assign fall      = ~touched & touched_d;
    assign hold_last = hold_cnt == HOLD_LAST;

`ifdef TOUCH_DTAP_EN
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(DTAP_GAP_CYC - 1);
    logic             dtap_nxt, gap_last;
    logic [CNT_W-1:0] gap_cnt;

    assign gap_last = gap_cnt == GAP_LAST;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_cnt    <= '0;
            dtap_pulse <= 1'b0;
        end else begin
            gap_cnt    <= (state == WAIT_GAP) ? ((gap_cnt == CNT_MAX) ? gap_cnt : gap_cnt + 1'b1) : '0;
            dtap_pulse <= dtap_nxt;
        end
    end
`else
    assign dtap_pulse = 1'b0;
`endif

    // State register; counters restart at zero on entry to the state that uses them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            hold_cnt   <= '0;
            tap_pulse  <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            busy       <= state_nxt != IDLE;
            tap_pulse  <= tap_nxt;
            long_pulse <= long_nxt;
`ifdef TOUCH_DTAP_EN
            hold_cnt   <= (state == PRESS1 || state == PRESS2) ?
                          ((hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + 1'b1) : '0;
`else
            hold_cnt   <= (state == PRESS1) ?
                          ((hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + 1'b1) : '0;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (rise) state_nxt = PRESS1;
`ifdef TOUCH_DTAP_EN
            PRESS1:    state_nxt = fall ? WAIT_GAP : hold_last ? LONG_HELD : state;
            // A rise landing on the gap terminal count still counts as a double tap.
            WAIT_GAP:  state_nxt = rise ? PRESS2 : gap_last ? IDLE : state;
            PRESS2:    state_nxt = fall ? IDLE : hold_last ? LONG_HELD : state;
`else
            PRESS1:    state_nxt = fall ? IDLE : hold_last ? LONG_HELD : state;
`endif
            LONG_HELD: if (fall) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
`ifdef TOUCH_DTAP_EN
        tap_nxt  = (state == WAIT_GAP) && !rise && gap_last;
        dtap_nxt = (state == PRESS2) && fall;
        long_nxt = (state == PRESS1 || state == PRESS2) && !fall && hold_last;
`else
        tap_nxt  = (state == PRESS1) && fall;
        long_nxt = (state == PRESS1) && !fall && hold_last;
`endif
    end
endmodule
